// File: rtl/sic_exec_alu_q.sv
// Buffered ALU execute sub-unit: in-order queue of issued packets, head executes and commits.
// Optional macro SIC_EXEC_ALU_Q_LOCK_HOLD_EN keeps the ALU lock across back-to-back ALU entries.
module sic_exec_alu_q #(
  parameter int SIC_ID   = 0,
  parameter int NUM_ECRS = 4,
  parameter int ID_WIDTH = 8,
  parameter int DEPTH    = 4,
  localparam int ECR_W   = (NUM_ECRS > 1) ? $clog2(NUM_ECRS) : 1,
  localparam int OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                req_instr,
  input  logic                in_valid,
  input  logic [ID_WIDTH-1:0] in_issue_id,
  input  logic [4:0]          in_rs,
  input  logic [4:0]          in_rt,
  input  logic                in_read_rs,
  input  logic                in_read_rt,
  input  logic                in_use_alu,
  input  logic                in_write_gpr,
  input  logic                in_wb_alu,
  input  logic                in_write_ecr,
  input  logic                in_is_bne,
  input  logic                in_pred_taken,
  input  logic                in_b_is_imm,
  input  logic                in_imm_zext,
  input  logic [5:0]          in_alu_op,
  input  logic [15:0]         in_imm16,
  input  logic [ECR_W-1:0]    in_set_ecr_id,
  input  logic [ECR_W-1:0]    in_dep_ecr_id,
  output logic [4:0]          rf_rs,
  output logic [4:0]          rf_rt,
  input  logic                rs_valid,
  input  logic                rt_valid,
  input  logic [31:0]         rs_rdata,
  input  logic [31:0]         rt_rdata,
  output logic [ECR_W-1:0]    ecr_raddr,
  input  logic [1:0]          ecr_rdata,
  output logic                alu_lock_req,
  output logic                alu_lock_release,
  output logic [ID_WIDTH-1:0] alu_lock_id,
  input  logic                alu_grant,
  output logic [5:0]          alu_op,
  output logic [31:0]         alu_a,
  output logic [31:0]         alu_b,
  input  logic [31:0]         alu_c,
  input  logic                alu_zero,
  output logic                rf_wcommit,
  output logic [31:0]         rf_wdata,
  output logic                ecr_wen,
  output logic [ECR_W-1:0]    ecr_waddr,
  output logic [1:0]          ecr_wdata,
  output logic [OCC_W-1:0]    occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0] issue_id;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic                read_rs;
    logic                read_rt;
    logic                use_alu;
    logic                write_gpr;
    logic                wb_alu;
    logic                write_ecr;
    logic                is_bne;
    logic                pred_taken;
    logic                b_is_imm;
    logic                imm_zext;
    logic [5:0]          alu_op;
    logic [15:0]         imm16;
    logic [ECR_W-1:0]    set_ecr_id;
    logic [ECR_W-1:0]    dep_ecr_id;
  } entry_t;

  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic zext);
    ext_imm = zext ? {16'b0, imm} : {{16{imm[15]}}, imm};
  endfunction

  function automatic logic is_shift_op(input logic [5:0] op);
    is_shift_op = (op == 6'h00) || (op == 6'h02) || (op == 6'h03);
  endfunction

  entry_t            mem_q [DEPTH];
  entry_t            in_entry;
  entry_t            head;
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [OCC_W-1:0]  cnt_q, cnt_d;
  logic              lock_held_q, lock_held_d;
  logic              release_q, release_d;
  logic              head_valid, push, rf_ok, lock_ok, abort, commit;
  logic              alu_commit, keep_lock, taken, shift;
  logic              unused_sic_id;

  assign unused_sic_id = (SIC_ID != 0);

  assign in_entry = '{issue_id: in_issue_id, rs: in_rs, rt: in_rt,
                      read_rs: in_read_rs, read_rt: in_read_rt, use_alu: in_use_alu,
                      write_gpr: in_write_gpr, wb_alu: in_wb_alu, write_ecr: in_write_ecr,
                      is_bne: in_is_bne, pred_taken: in_pred_taken, b_is_imm: in_b_is_imm,
                      imm_zext: in_imm_zext, alu_op: in_alu_op, imm16: in_imm16,
                      set_ecr_id: in_set_ecr_id, dep_ecr_id: in_dep_ecr_id};

  assign req_instr  = (cnt_q != OCC_W'(DEPTH));
  assign push       = in_valid & req_instr;
  assign head_valid = (cnt_q != '0);
  assign head       = mem_q[rd_q];
  assign shift      = is_shift_op(head.alu_op);

  // Issue handshake and commit decision for the head entry
  assign rf_ok  = (!head.read_rs | rs_valid) & (!head.read_rt | rt_valid);
  assign lock_ok = alu_grant | lock_held_q;
  assign abort  = head_valid & (ecr_rdata == 2'b10);
  assign commit = head_valid & rf_ok & (!head.use_alu | lock_ok) & !abort
                & (!head.write_ecr | (ecr_rdata == 2'b01));
  assign taken  = head.is_bne ? !alu_zero : alu_zero;

  assign rf_rs       = head_valid ? head.rs : '0;
  assign rf_rt       = head_valid ? head.rt : '0;
  assign ecr_raddr   = head_valid ? head.dep_ecr_id : '0;
  assign alu_lock_id = head_valid ? head.issue_id : '0;
  assign alu_op      = head_valid ? head.alu_op : '0;
  assign alu_a       = !head_valid ? '0 : shift ? {27'b0, head.imm16[10:6]} : rs_rdata;
  assign alu_b       = !head_valid ? '0 : (shift || !head.b_is_imm) ? rt_rdata
                     : ext_imm(head.imm16, head.imm_zext);
  assign alu_lock_req = head_valid & head.use_alu & !abort & !lock_held_q & !release_q;
  assign alu_lock_release = release_q;

  assign rf_wcommit = commit & head.write_gpr & head.wb_alu;
  assign rf_wdata   = rf_wcommit ? alu_c : '0;
  assign ecr_wen    = commit & head.write_ecr;
  assign ecr_waddr  = ecr_wen ? head.set_ecr_id : '0;
  assign ecr_wdata  = !ecr_wen ? 2'b00 : (taken == head.pred_taken) ? 2'b01 : 2'b10;
  assign occupancy  = cnt_q;

  assign alu_commit = commit & head.use_alu;

`ifdef SIC_EXEC_ALU_Q_LOCK_HOLD_EN
  logic [PTR_W-1:0] nxt_ptr;
  logic             nxt_use_alu;
  assign nxt_ptr     = rd_q + PTR_W'(1);
  assign nxt_use_alu = mem_q[nxt_ptr].use_alu;
  assign keep_lock   = alu_commit & (cnt_q > OCC_W'(1)) & nxt_use_alu;
  always_comb begin
    lock_held_d = lock_held_q;
    if (abort)           lock_held_d = 1'b0;
    else if (alu_commit) lock_held_d = keep_lock;
  end
`else
  assign keep_lock   = 1'b0;
  assign lock_held_d = 1'b0;
`endif

  // Any lock owned by the head is given back on a non-chained commit or a flush
  assign release_d = (alu_commit & !keep_lock) | (abort & head.use_alu & lock_ok);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (abort) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push)   wr_d = wr_q + PTR_W'(1);
      if (commit) rd_d = rd_q + PTR_W'(1);
      cnt_d = cnt_q + OCC_W'(push) - OCC_W'(commit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      lock_held_q <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      lock_held_q <= lock_held_d;
      release_q   <= release_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by cnt_q
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_entry;
  end

endmodule

// File: tb/tb_sic_exec_alu_q.sv
// Directed scoreboard bench for sic_exec_alu_q; follows SIC_EXEC_ALU_Q_LOCK_HOLD_EN when defined.
module tb_sic_exec_alu_q;
  localparam int ECR_W = 2;
  localparam int OCC_W = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic req_instr, in_valid;
  logic [7:0] in_issue_id;
  logic [4:0] in_rs, in_rt;
  logic in_read_rs, in_read_rt, in_use_alu, in_write_gpr, in_wb_alu, in_write_ecr;
  logic in_is_bne, in_pred_taken, in_b_is_imm, in_imm_zext;
  logic [5:0] in_alu_op;
  logic [15:0] in_imm16;
  logic [ECR_W-1:0] in_set_ecr_id, in_dep_ecr_id;
  logic [4:0] rf_rs, rf_rt;
  logic rs_valid, rt_valid;
  logic [31:0] rs_rdata, rt_rdata;
  logic [ECR_W-1:0] ecr_raddr;
  logic [1:0] ecr_rdata;
  logic alu_lock_req, alu_lock_release, alu_grant;
  logic [7:0] alu_lock_id;
  logic [5:0] alu_op;
  logic [31:0] alu_a, alu_b, alu_c;
  logic alu_zero;
  logic rf_wcommit;
  logic [31:0] rf_wdata;
  logic ecr_wen;
  logic [ECR_W-1:0] ecr_waddr;
  logic [1:0] ecr_wdata;
  logic [OCC_W-1:0] occupancy;

  logic grant_en, zero_drv;
  int checks = 0;
  int errors = 0;
  int n_rel = 0;
  logic seen_commit, seen_rel, obs_req;
  logic [OCC_W-1:0] obs_occ;
  logic [33:0] exp_q[$];
  logic [7:0] next_id = 8'd0;

  always #5 clk = ~clk;

  // Arbiter grants whatever is requested; ALU adds its operands
  assign alu_grant = grant_en & alu_lock_req;
  assign alu_c     = alu_a + alu_b;
  assign alu_zero  = zero_drv;

  sic_exec_alu_q #(.SIC_ID(0), .NUM_ECRS(4), .ID_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_instr(req_instr), .in_valid(in_valid),
    .in_issue_id(in_issue_id), .in_rs(in_rs), .in_rt(in_rt),
    .in_read_rs(in_read_rs), .in_read_rt(in_read_rt), .in_use_alu(in_use_alu),
    .in_write_gpr(in_write_gpr), .in_wb_alu(in_wb_alu), .in_write_ecr(in_write_ecr),
    .in_is_bne(in_is_bne), .in_pred_taken(in_pred_taken), .in_b_is_imm(in_b_is_imm),
    .in_imm_zext(in_imm_zext), .in_alu_op(in_alu_op), .in_imm16(in_imm16),
    .in_set_ecr_id(in_set_ecr_id), .in_dep_ecr_id(in_dep_ecr_id),
    .rf_rs(rf_rs), .rf_rt(rf_rt), .rs_valid(rs_valid), .rt_valid(rt_valid),
    .rs_rdata(rs_rdata), .rt_rdata(rt_rdata), .ecr_raddr(ecr_raddr), .ecr_rdata(ecr_rdata),
    .alu_lock_req(alu_lock_req), .alu_lock_release(alu_lock_release),
    .alu_lock_id(alu_lock_id), .alu_grant(alu_grant), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_zero(alu_zero),
    .rf_wcommit(rf_wcommit), .rf_wdata(rf_wdata), .ecr_wen(ecr_wen),
    .ecr_waddr(ecr_waddr), .ecr_wdata(ecr_wdata), .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input logic [1:0] kind, input logic [31:0] data);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected_commit", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("sb_kind", 32'(kind), 32'(e[33:32]));
      chk("sb_data", data, e[31:0]);
    end
  endtask

  // Observe the current cycle mid-period, then advance to the next falling edge
  task automatic tick();
    #1;
    seen_commit = rf_wcommit | ecr_wen;
    seen_rel    = alu_lock_release;
    obs_occ     = occupancy;
    obs_req     = req_instr;
    if (rf_wcommit) sb_check(2'd1, rf_wdata);
    if (ecr_wen)    sb_check(2'd2, {28'b0, ecr_waddr, ecr_wdata});
    if (alu_lock_release) n_rel++;
    @(negedge clk);
  endtask

  task automatic push_pkt(input logic [5:0] op, input logic [15:0] imm, input logic br,
                          input logic bne, input logic pred, input logic [1:0] set_id,
                          input logic exp_en, input logic [31:0] exp_val);
    in_issue_id   = next_id;
    next_id       = next_id + 8'd1;
    in_rs         = 5'd7;
    in_rt         = 5'd9;
    in_read_rs    = 1'b1;
    in_read_rt    = br;
    in_use_alu    = 1'b1;
    in_write_gpr  = !br;
    in_wb_alu     = 1'b1;
    in_write_ecr  = br;
    in_is_bne     = bne;
    in_pred_taken = pred;
    in_b_is_imm   = !br;
    in_imm_zext   = 1'b0;
    in_alu_op     = op;
    in_imm16      = imm;
    in_set_ecr_id = set_id;
    in_dep_ecr_id = 2'd0;
    if (exp_en) exp_q.push_back({br ? 2'd2 : 2'd1, exp_val});
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cc[2];
    int rel0;
    rst_n = 1'b0; in_valid = 1'b0; grant_en = 1'b1; zero_drv = 1'b0;
    in_issue_id = '0; in_rs = '0; in_rt = '0; in_read_rs = 0; in_read_rt = 0;
    in_use_alu = 0; in_write_gpr = 0; in_wb_alu = 0; in_write_ecr = 0; in_is_bne = 0;
    in_pred_taken = 0; in_b_is_imm = 0; in_imm_zext = 0; in_alu_op = '0; in_imm16 = '0;
    in_set_ecr_id = '0; in_dep_ecr_id = '0;
    rs_valid = 1'b1; rt_valid = 1'b1; rs_rdata = 32'd5; rt_rdata = 32'd3; ecr_rdata = 2'b01;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_req_instr", 32'(req_instr), 32'd1);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_lock_req", 32'(alu_lock_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDIU rs=7, imm=0xFFFF: commits the cycle after the push, release follows
    push_pkt(6'h09, 16'hFFFF, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd4);
    chk("t1_no_commit_on_push", 32'(seen_commit), 32'd0);
    #1;
    chk("t1_rf_rs", 32'(rf_rs), 32'd7);
    tick();
    chk("t1_commit", 32'(seen_commit), 32'd1);
    chk("t1_release_not_yet", 32'(seen_rel), 32'd0);
    tick();
    chk("t1_release_pulse", 32'(seen_rel), 32'd1);
    tick();

    // Fill the queue while operands are not ready
    rs_valid = 1'b0;
    push_pkt(6'h09, 16'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd6);
    push_pkt(6'h09, 16'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd7);
    push_pkt(6'h09, 16'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd8);
    push_pkt(6'h09, 16'd4, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd9);
    tick();
    chk("t2_full_req", 32'(obs_req), 32'd0);
    chk("t2_full_occ", 32'(obs_occ), 32'd4);
    rs_valid = 1'b1;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (seen_commit) begin
        chk("t2_occ_countdown", 32'(obs_occ), 32'(4 - k));
        k++;
      end
    end
    chk("t2_commits", 32'(k), 32'd4);
    chk("t2_occ_zero", 32'(occupancy), 32'd0);

    // BNE predicted not-taken, ALU not zero -> actually taken -> mispredict
    zero_drv = 1'b0;
    push_pkt(6'h05, 16'd0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 32'h0000_000A);
    tick();
    chk("t3_bne_commit", 32'(seen_commit), 32'd1);
    tick(); tick();
    // BEQ predicted taken with zero set; held while its ECR predecessor is pending
    zero_drv = 1'b1;
    ecr_rdata = 2'b00;
    push_pkt(6'h05, 16'd0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 32'h0000_000D);
    tick();
    chk("t3_pending_hold", 32'(seen_commit), 32'd0);
    chk("t3_pending_occ", 32'(obs_occ), 32'd1);
    ecr_rdata = 2'b01;
    tick();
    chk("t3_beq_commit", 32'(seen_commit), 32'd1);
    tick(); tick();
    zero_drv = 1'b0;

    // Mispredict abort with three entries queued and a simultaneous push
    rs_valid = 1'b0;
    push_pkt(6'h09, 16'd10, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0);
    push_pkt(6'h09, 16'd11, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0);
    push_pkt(6'h09, 16'd12, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0);
    rs_valid = 1'b1;
    ecr_rdata = 2'b10;
    push_pkt(6'h09, 16'd13, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0);
    chk("t4_abort_no_commit", 32'(seen_commit), 32'd0);
    ecr_rdata = 2'b01;
    tick();
    chk("t4_abort_occ", 32'(obs_occ), 32'd0);
    chk("t4_abort_req", 32'(obs_req), 32'd1);
    chk("t4_abort_no_release", 32'(seen_rel), 32'd0);
    tick();

    // Two ALU entries queued before the lock is granted
    grant_en = 1'b0;
    push_pkt(6'h09, 16'h0010, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'd21);
    push_pkt(6'h09, 16'h8000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'hFFFF_8005);
    grant_en = 1'b1;
    rel0 = n_rel;
    k = 0;
    cc[0] = 0; cc[1] = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (seen_commit && k < 2) begin
        cc[k] = i;
        k++;
      end
    end
    chk("t5_commits", 32'(k), 32'd2);
`ifdef SIC_EXEC_ALU_Q_LOCK_HOLD_EN
    chk("t5_commit_gap", 32'(cc[1] - cc[0]), 32'd1);
    chk("t5_release_count", 32'(n_rel - rel0), 32'd1);
`else
    chk("t5_commit_gap", 32'(cc[1] - cc[0]), 32'd2);
    chk("t5_release_count", 32'(n_rel - rel0), 32'd2);
`endif

    // Reset while two entries wait on the lock
    grant_en = 1'b0;
    push_pkt(6'h09, 16'd20, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0);
    push_pkt(6'h09, 16'd21, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 32'(req_instr), 32'd1);
    chk("t6_rst_occ", 32'(occupancy), 32'd0);
    chk("t6_rst_rf_rs", 32'(rf_rs), 32'd0);
    chk("t6_rst_alu_op", 32'(alu_op), 32'd0);
    chk("t6_rst_lock_id", 32'(alu_lock_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    grant_en = 1'b1;
    tick();
    chk("t6_no_release", 32'(seen_rel), 32'd0);
    chk("t6_no_commit", 32'(seen_commit), 32'd0);
    chk("t6_occ", 32'(obs_occ), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sic_exec_alu_q.md
# sic_exec_alu_q

Buffered, parametrised ALU execute sub-unit of a SIC (single-issue cluster).
- Holds up to DEPTH issued packets in an in-order queue, so issue is not stalled while the head instruction waits on operands, the ALU lock or a predecessor ECR.
- Executes the head entry and commits ALU results to the register file. Branch entries resolve by writing the ECR.
- Flushes all queued entries on a mispredict abort.
- Optionally keeps the shared ALU lock across back-to-back ALU entries.

## Interface
Parameters:
- SIC_ID, 0, cluster index; not used functionally.
- NUM_ECRS, 4, number of ECRs; ECR_W = max(1, clog2(NUM_ECRS)).
- ID_WIDTH, 8, issue-id width.
- DEPTH, 4, queue entries; power of two, ≥2.

Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_instr  out  1  queue can accept a packet this cycle (count < DEPTH)
- in_valid  in  1  push packet; legal only while req_instr=1
- in_issue_id  in  ID_WIDTH  issue id
- in_rs, in_rt  in  5 each  source register addresses
- in_read_rs, in_read_rt, in_use_alu, in_write_gpr, in_wb_alu, in_write_ecr, in_is_bne, in_pred_taken, in_b_is_imm, in_imm_zext  in  1 each  decode flags
- in_alu_op  in  6  ALU opcode
- in_imm16  in  16  immediate
- in_set_ecr_id  in  ECR_W  ECR written by this branch
- in_dep_ecr_id  in  ECR_W  ECR this packet is speculative on
- rf_rs, rf_rt  out  5 each  head source addresses
- rs_valid, rt_valid  in  1 each  operand ready
- rs_rdata, rt_rdata  in  32 each  operand data
- ecr_raddr  out  ECR_W  head in_dep_ecr_id
- ecr_rdata  in  2  01 = confirmed, 10 = mispredict, else pending
- alu_lock_req, alu_lock_release  out  1 each  ALU lock request; one-cycle release pulse
- alu_lock_id  out  ID_WIDTH  head issue id
- alu_grant  in  1  lock granted
- alu_op  out  6  head opcode
- alu_a, alu_b  out  32 each  ALU operands
- alu_c  in  32  ALU result
- alu_zero  in  1  ALU zero flag
- rf_wcommit  out  1  GPR write strobe
- rf_wdata  out  32  GPR write data (alu_c)
- ecr_wen  out  1  ECR write strobe
- ecr_waddr  out  ECR_W  ECR write address
- ecr_wdata  out  2  ECR write value
- occupancy  out  clog2(DEPTH+1)  valid entry count

## Operation
- Circular queue: wr/rd pointers with wrap, plus a count. A push stores all in_* fields at wr_ptr. The head is the entry at rd_ptr.
- Operands:
  - is_shift when op ∈ {00,02,03}.
  - a = is_shift ? {27'b0, imm16[10:6]} : rs_rdata.
  - b = is_shift ? rt_rdata : (b_is_imm ? (imm_zext ? zero-ext : sign-ext) : rt_rdata).
- rf_ok = (!read_rs | rs_valid) & (!read_rt | rt_valid).
- abort = head_valid & ecr_rdata==10.
- commit = head_valid & rf_ok & (!use_alu | lock_ok) & !abort & (!write_ecr | ecr_rdata==01).
  - lock_ok = alu_grant | lock_held.
- On commit:
  - rf_wcommit = write_gpr & wb_alu.
  - ecr_wen = write_ecr; ecr_waddr = set_ecr_id.
  - taken = is_bne ? !zero : zero; ecr_wdata = (taken==pred_taken) ? 01 : 10.
  - Pop the head.
- On abort, every entry is invalidated, including a push accepted in the same cycle. Count resets to 0.
- alu_lock_req = head_valid & use_alu & !abort & !lock_held & !release_pending.
- A commit and a push in the same cycle leave the count unchanged. A full queue with a commit still reports req_instr=0; there is no bypass.

## Timing
- Reset values:
  - All outputs 0, except rf_rs, rf_rt, ecr_raddr, alu_* = 0 and req_instr = 1 (queue empty).
  - Queue empty; lock_held = 0.
- Push-to-earliest-commit latency is 1 cycle: a pushed entry becomes head on the next cycle when the queue was empty.
- All commit/ECR/RF strobes are combinational from the head in the commit cycle.
- alu_lock_release is a registered pulse, asserted in the cycle after the event that drops the lock.
- Reset asserted mid-operation empties the queue immediately. No release pulse is generated.

## Configuration
- SIC_EXEC_ALU_Q_LOCK_HOLD_EN defined:
  - On an ALU commit where entry rd_ptr+1 is valid and use_alu=1, lock_held stays 1 and no release is issued.
  - The next entry can commit in the following cycle without re-requesting the lock.
  - Otherwise the release pulse follows the commit.
  - On abort while lock_held=1, the release pulse follows and lock_held clears.
- Undefined:
  - lock_held is always 0; every ALU commit or ALU-holding abort yields a release pulse next cycle.
  - release_pending suppresses alu_lock_req during that pulse cycle, so the best case is 1 ALU commit per 2 cycles.

## Test plan
- Empty queue, push ADDIU (rs=7, imm=0xFFFF), rs_valid=1, rs_rdata=5, grant=1 -> commit next cycle, rf_wdata=4, release pulse one cycle later.
- Push 4 packets with rs_valid=0 -> req_instr=0 and occupancy=4. Raise rs_valid -> in-order commits, occupancy counting down to 0.
- BNE pred_taken=0, alu_zero=0, ecr_rdata=01 -> ecr_wen=1, ecr_wdata=10.
- 3 queued entries, ecr_rdata=10, with a simultaneous push -> no commit strobes; occupancy=0 next cycle.
- Two back-to-back ALU entries with the macro -> commits in consecutive cycles, exactly one release pulse. Without the macro -> commits 2 cycles apart, two release pulses.
- Reset asserted while 2 entries are waiting on the lock -> all outputs at reset values, req_instr=1, no release pulse.
